sram_128b_port_ctrl: RTL
========================

Name: sram_128b_port_ctrl

Overview:
Initiator-side controller for the 128-bit single-port byte-strobed SRAM macro used in the iDMA/iNoC buffer. It accepts a valid/ready request stream from DMA engines and drives the SRAM cen/wen/addr/wdata/wstrb pins. It absorbs the SRAM's fixed 1-cycle read latency into a credit-protected response FIFO, so response backpressure never loses read data. The SRAM writes unstrobed bytes as zero; the controller can optionally hide this with read-modify-write.

Parameters:
ADDR_W, 15, SRAM word-address width; must match the SRAM instance.
RSP_DEPTH, 4, response FIFO entries; minimum 2; a value of 3 or more sustains one read per cycle.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request valid
req_ready  output  1  request accepted when valid && ready
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  word address
req_wdata  input  128  write data
req_wstrb  input  16  byte strobes; bit i covers bits [8i+7:8i]
rsp_valid  output  1  read data valid
rsp_ready  input  1  response sink ready
rsp_rdata  output  128  read data
sram_cen  output  1  SRAM access enable, active-high
sram_wen  output  1  SRAM write enable, active-high
sram_addr  output  ADDR_W  SRAM address
sram_wdata  output  128  SRAM write data
sram_wstrb  output  16  SRAM byte strobes
sram_rdata  input  128  SRAM registered read data; valid the cycle after address presentation

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous, active-low (rst_n).
- Reset values: rsp_valid=0, sram_cen=0, sram_wen=0, FIFO empty, inflight=0, state=IDLE. req_ready is forced 0 while rst_n=0.
- SRAM pins in IDLE are combinational from the request on the handshake cycle:
  - sram_addr=req_addr.
  - sram_cen=1 on any accepted access.
  - sram_wen=1 on an accepted write.
  - Otherwise sram_cen=sram_wen=0, and sram_addr/sram_wdata/sram_wstrb follow req_* (don't-care).
- Reads:
  - Accepted at cycle T. The inflight flag is set at the T edge.
  - sram_rdata is pushed into the FIFO at the end of T+1.
  - rsp_valid rises at T+2, so latency is fixed at 2 cycles when the FIFO is empty.
  - Responses are returned in request order.
- Read credit:
  - A read is ready only when fifo_count + inflight < RSP_DEPTH.
  - A same-cycle pop is not credited, so there is no combinational path from rsp_ready to req_ready.
- Writes:
  - No response is generated.
  - Writes need no credit; they are ready whenever state=IDLE, even with the FIFO full.
  - The write commits at the end of the handshake cycle.
- Ordering:
  - Read at T then write at T+1 to the same address: the read returns the old data.
  - Write at T then read at T+1: the read returns the new data.
- FIFO:
  - Simultaneous push and pop leaves the count unchanged.
  - A pop from empty or a push to full cannot occur by construction; assertions in the bench check this.
  - Pointers wrap modulo RSP_DEPTH.
- rsp_rdata holds stable while rsp_valid && !rsp_ready.
- Reset mid-operation: the inflight read, FIFO contents and any RMW are discarded; no SRAM write is issued after reset asserts.

Optional Feature:
SRAM_PORT_RMW_EN
- Defined, partial-strobe write (wstrb not 16'hFFFF and not 0):
  - Handshake cycle T: state IDLE->RMW_WR. The SRAM is driven as a read (cen=1, wen=0). addr, wdata and wstrb are latched.
  - Cycle T+1 (RMW_WR): req_ready=0. Drive cen=1, wen=1, wstrb=16'hFFFF, wdata=(wdata_q & mask) | (sram_rdata & ~mask). Return to IDLE.
  - RMW reads never enter the FIFO or touch inflight.
  - A pending inflight normal read is still pushed correctly during RMW_WR.
- Defined, wstrb=0: no-op. cen=0, single cycle.
- Defined, full-strobe write: single cycle, as in the base mode.
- Not defined:
  - No RMW_WR state exists.
  - Writes pass through; unstrobed bytes are written as zero.
  - wstrb=0 clears the word.

Test Plan:
- Write addr 0x10, data 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, wstrb 16'hFFFF; read 0x10 next cycle -> rsp_valid exactly 2 cycles after the read handshake, same data.
- 8 back-to-back reads to addr 0..7 preloaded with value=addr, rsp_ready=1 -> req_ready stays 1; responses 0..7 on 8 consecutive cycles starting at T+2.
- rsp_ready=0, continuous reads -> exactly 4 reads accepted, then req_ready=0 while a write is still accepted; raise rsp_ready -> 4 ordered responses, reads resume.
- Preload 0x20 with all-ones; write 0x20 with wdata=0, wstrb 16'h000F; read back:
  - RMW defined: 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000_0000, and req_ready=0 for one cycle.
  - RMW not defined: all zero.
- Read addr A holding X, then write A with Y at the next cycle -> response X; a subsequent read returns Y.
- Assert rst_n low during RMW_WR -> sram_cen=sram_wen=0 immediately; rsp_valid=0; memory word unchanged.

Source files
------------

// File: rtl/sram_128b_port_ctrl.sv
// -----------------------------------------------------------------------------
// sram_128b_port_ctrl
//
// Initiator-side controller for a 128-bit single-port, byte-strobed SRAM macro.
// A valid/ready request stream (reads and writes) is turned into SRAM pin
// activity. The SRAM's fixed one-cycle read latency is absorbed by a small
// response FIFO. Reads are only accepted when a FIFO slot is guaranteed, so a
// stalled response sink can never cause read data to be dropped.
//
// Optional feature (compile-time macro SRAM_PORT_RMW_EN):
//   When defined, partial-strobe writes are performed as read-modify-write so
//   that unstrobed bytes keep their old contents (the raw SRAM writes them as
//   zero). A write with no strobes set becomes a no-op. When undefined, writes
//   pass straight through to the SRAM.
//
// Parameters:
//   ADDR_W     SRAM word-address width
//   RSP_DEPTH  response FIFO entries (>= 2; >= 3 sustains one read per cycle)
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   req_valid/req_ready          request handshake
//   req_we                       1 = write, 0 = read
//   req_addr/req_wdata/req_wstrb request word address, data, byte strobes
//   rsp_valid/rsp_ready          read response handshake
//   rsp_rdata                    read response data (stable while stalled)
//   sram_cen/sram_wen            SRAM access enable / write enable (active-high)
//   sram_addr/sram_wdata         SRAM address and write data
//   sram_wstrb                   SRAM byte strobes
//   sram_rdata                   SRAM read data, valid the cycle after address
// -----------------------------------------------------------------------------
module sram_128b_port_ctrl #(
  parameter int ADDR_W    = 15,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [127:0]      req_wdata,
  input  logic [15:0]       req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [127:0]      rsp_rdata,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [127:0]      sram_wdata,
  output logic [15:0]       sram_wstrb,
  input  logic [127:0]      sram_rdata
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(RSP_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RSP_DEPTH - 1);

  logic [127:0]     fifo_mem [RSP_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic             inflight;
  logic [CNT_W:0]   credit_used;
  logic             credit_ok;
  logic             in_idle;
  logic             req_hs;
  logic             read_hs;
  logic             push;
  logic             pop;

  // A read needs a FIFO slot reserved for its data, counting the one already
  // in flight. The pop happening this cycle is deliberately ignored so that
  // req_ready never depends combinationally on rsp_ready.
  assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
  assign credit_ok   = credit_used < DEPTH_C;

  // Writes never need credit; they only wait for the controller to be idle.
  assign req_ready = rst_n && in_idle && (req_we || credit_ok);
  assign req_hs    = req_valid && req_ready;
  assign read_hs   = req_hs && !req_we;

  // The SRAM data for a read accepted last cycle is on sram_rdata now.
  assign push      = inflight;
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_valid = (fifo_count != '0);
  assign rsp_rdata = fifo_mem[rd_ptr];

  // Read tracking and FIFO bookkeeping. Pointers wrap explicitly so that
  // non-power-of-two depths work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      inflight <= read_hs;
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage needs no reset; the count alone says what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= sram_rdata;
    end
  end

`ifdef SRAM_PORT_RMW_EN

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [127:0]      wdata_q;
  logic [15:0]       wstrb_q;
  logic [127:0]      byte_mask;
  logic [127:0]      merged;
  logic              partial_wr;
  logic              null_wr;

  assign partial_wr = req_we && (req_wstrb != 16'hFFFF) && (req_wstrb != 16'h0000);
  assign null_wr    = req_we && (req_wstrb == 16'h0000);
  assign in_idle    = (state == IDLE);

  // Expand the latched byte strobes into a bit mask for the merge.
  always_comb begin
    byte_mask = '0;
    for (int i = 0; i < 16; i++) begin
      byte_mask[8*i +: 8] = {8{wstrb_q[i]}};
    end
  end

  // New bytes where strobed, old SRAM contents everywhere else.
  assign merged = (wdata_q & byte_mask) | (sram_rdata & ~byte_mask);

  // A partial write spends one cycle reading the old word, then one cycle
  // writing the merged word. Reset drops straight back to IDLE, which
  // removes the pending write from the SRAM pins immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_hs && partial_wr) begin
            state   <= RMW_WR;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
          end
        end
        RMW_WR:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // SRAM pin drive. In IDLE a partial write shows up as a read of the target
  // word; an all-zero strobe write is accepted but touches nothing.
  always_comb begin
    sram_cen   = 1'b0;
    sram_wen   = 1'b0;
    sram_addr  = req_addr;
    sram_wdata = req_wdata;
    sram_wstrb = req_wstrb;
    if (state == RMW_WR) begin
      sram_cen   = 1'b1;
      sram_wen   = 1'b1;
      sram_addr  = addr_q;
      sram_wdata = merged;
      sram_wstrb = 16'hFFFF;
    end else if (req_hs && !null_wr) begin
      sram_cen = 1'b1;
      sram_wen = req_we && !partial_wr;
    end
  end

`else

  // Every request completes in its handshake cycle, so the controller is
  // always idle.
  assign in_idle = 1'b1;

  // Requests pass straight through to the SRAM on the handshake cycle.
  always_comb begin
    sram_cen   = req_hs;
    sram_wen   = req_hs && req_we;
    sram_addr  = req_addr;
    sram_wdata = req_wdata;
    sram_wstrb = req_wstrb;
  end

`endif

endmodule
